// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result stage behind the 64-bit ALU.
// Captures alu_data with the PSW flags derived from a/b/cmd and hands
// the results downstream through a 2-entry skid buffer (head + tail).
module alu_result_stage #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] alu_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [31:0]      out_psw,
    output logic [3:0]       out_cmd
);

    // Occupancy-encoded states: the encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [3:0] CMD_ADD = 4'd0;
    localparam logic [3:0] CMD_SUB = 4'd1;
    localparam logic [1:0] FULL_OCC = 2'(DEPTH);

    // PSW flags from unsigned WIDTH-bit arithmetic on the operands.
    function automatic logic [31:0] calc_psw(
        input logic [WIDTH-1:0] fa,
        input logic [WIDTH-1:0] fb,
        input logic [3:0]       fcmd
    );
        logic [WIDTH:0] sum;
        logic           legal;
        logic [31:0]    psw;
        sum = {1'b0, fa} + {1'b0, fb};
        case (fcmd)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        psw    = 32'd0;
        psw[0] = (fcmd == CMD_ADD) ? sum[WIDTH] : 1'b0;
        psw[1] = (fcmd == CMD_SUB) ? (fa < fb) : 1'b0;
        psw[2] = (fa > fb);
        psw[3] = (fa == fb);
        psw[4] = (fa < fb);
        psw[5] = ~legal;
        return psw;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_head_data;
    logic [31:0]       r_head_psw;
    logic [3:0]        r_head_cmd;
    logic [WIDTH-1:0]  r_tail_data;
    logic [31:0]       r_tail_psw;
    logic [3:0]        r_tail_cmd;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_in_psw;

    assign w_push   = in_valid & r_in_ready;
    assign w_pop    = r_out_valid & out_ready;
    assign w_in_psw = calc_psw(a, b, cmd);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_head_data;
    assign out_psw   = r_head_psw;
    assign out_cmd   = r_head_cmd;

    // Next occupancy state from push/pop; TWO never pushes because in_ready is low.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ST_ONE;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_push && !w_pop) begin
                    w_state_nxt = ST_TWO;
                end else if (w_pop && !w_push) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_state_nxt = ST_ONE;
                end else begin
                    w_state_nxt = ST_TWO;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State register plus registered handshake flags decoded from the next state,
    // so in_ready has no combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (2'(w_state_nxt) != FULL_OCC);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Head/tail entry storage; the tail only fills when the head is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_data <= '0;
            r_head_psw  <= 32'd0;
            r_head_cmd  <= 4'd0;
            r_tail_data <= '0;
            r_tail_psw  <= 32'd0;
            r_tail_cmd  <= 4'd0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_head_data <= alu_data;
                        r_head_psw  <= w_in_psw;
                        r_head_cmd  <= cmd;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_head_data <= alu_data;
                        r_head_psw  <= w_in_psw;
                        r_head_cmd  <= cmd;
                    end else if (w_push) begin
                        r_tail_data <= alu_data;
                        r_tail_psw  <= w_in_psw;
                        r_tail_cmd  <= cmd;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_head_data <= r_tail_data;
                        r_head_psw  <= r_tail_psw;
                        r_head_cmd  <= r_tail_cmd;
                    end
                end
                default: begin
                    r_head_data <= r_head_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a queue-based reference model.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  cmd;
    logic [63:0] alu_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [31:0] out_psw;
    logic [3:0]  out_cmd;

    typedef struct {
        logic [63:0] d;
        logic [31:0] p;
        logic [3:0]  c;
    } ent_t;

    ent_t q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(64), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cmd(cmd), .alu_data(alu_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_psw(out_psw), .out_cmd(out_cmd)
    );

    // Reference PSW straight from the flag definitions.
    function automatic logic [31:0] model_psw(input logic [63:0] ma, input logic [63:0] mb, input logic [3:0] mc);
        logic [64:0] s;
        logic [31:0] p;
        s = {1'b0, ma} + {1'b0, mb};
        p = 32'd0;
        if (mc == 4'd0 && s > {1'b0, {64{1'b1}}}) p = p | 32'h01;
        if (mc == 4'd1 && ma < mb)                p = p | 32'h02;
        if (ma > mb)                              p = p | 32'h04;
        if (ma == mb)                             p = p | 32'h08;
        if (ma < mb)                              p = p | 32'h10;
        if (!(mc inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8})) p = p | 32'h20;
        return p;
    endfunction

    // Stand-in ALU used to produce alu_data for the throughput run.
    function automatic logic [63:0] alu(input logic [63:0] fa, input logic [63:0] fb, input logic [3:0] fc);
        case (fc)
            4'd0:    return fa + fb;
            4'd1:    return fa - fb;
            4'd2:    return fa & fb;
            4'd3:    return fa | fb;
            4'd4:    return ~fa;
            4'd6:    return fa << fb[5:0];
            4'd7:    return fa >> fb[5:0];
            4'd8:    return 64'($signed(fa) >>> fb[5:0]);
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: FIFO of capacity two, pop before push, cleared by reset.
    always @(posedge clk) begin
        ent_t e;
        bit   push;
        bit   pop;
        if (rst) begin
            q.delete();
        end else begin
            push = in_valid && (q.size() < 2);
            pop  = (q.size() > 0) && out_ready;
            e.d = alu_data;
            e.p = model_psw(a, b, cmd);
            e.c = cmd;
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(e);
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            chk("model_in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
            if (q.size() > 0) begin
                chk("model_out_data", out_data, q[0].d);
                chk("model_out_psw", {32'd0, out_psw}, {32'd0, q[0].p});
                chk("model_out_cmd", {60'd0, out_cmd}, {60'd0, q[0].c});
            end
        end
    end

    task automatic cyc(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                       input logic [3:0] ic, input logic [63:0] id, input logic ordy);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cmd       = ic;
        alu_data  = id;
        out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0]  legal_cmds [8];
        logic [63:0] ai;
        logic [63:0] bi;
        logic [63:0] exp_d;
        legal_cmds = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8};

        rst = 1'b1;
        cyc(1'b0, 64'd0, 64'd0, 4'd0, 64'd0, 1'b0);
        cyc(1'b1, 64'd9, 64'd9, 4'd0, 64'd9, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_psw", {32'd0, out_psw}, 64'd0);
        chk("rst_out_cmd", {60'd0, out_cmd}, 64'd0);

        // ADD with carry out
        cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h30, 4'd0, 64'h2F, 1'b1);
        chk("add_valid", {63'd0, out_valid}, 64'd1);
        chk("add_data", out_data, 64'h2F);
        chk("add_psw", {32'd0, out_psw}, 64'h05);

        // SUB equal, then SUB with borrow (push & pop in ONE)
        cyc(1'b1, 64'h5, 64'h5, 4'd1, 64'h0, 1'b1);
        chk("sub_eq_data", out_data, 64'h0);
        chk("sub_eq_psw", {32'd0, out_psw}, 64'h08);
        cyc(1'b1, 64'h3, 64'h7, 4'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        chk("sub_lt_psw", {32'd0, out_psw}, 64'h12);
        chk("sub_lt_data", out_data, 64'hFFFF_FFFF_FFFF_FFFC);

        // Illegal opcode, then SRA is legal
        cyc(1'b1, 64'h1, 64'h2, 4'd5, 64'h0, 1'b1);
        chk("ill_psw", {32'd0, out_psw}, 64'h30);
        chk("ill_data", out_data, 64'h0);
        chk("ill_cmd", {60'd0, out_cmd}, 64'd5);
        cyc(1'b1, 64'h1, 64'h2, 4'd8, 64'h0, 1'b1);
        chk("sra_psw", {32'd0, out_psw}, 64'h10);
        cyc(1'b0, 64'h0, 64'h0, 4'd0, 64'h0, 1'b1);
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: three ADDs with out_ready low
        cyc(1'b1, 64'h10, 64'h1, 4'd0, 64'h11, 1'b0);
        chk("bp1_ready", {63'd0, in_ready}, 64'd1);
        chk("bp1_data", out_data, 64'h11);
        cyc(1'b1, 64'h20, 64'h2, 4'd0, 64'h22, 1'b0);
        chk("bp2_ready", {63'd0, in_ready}, 64'd0);
        chk("bp2_data", out_data, 64'h11);
        cyc(1'b1, 64'h30, 64'h3, 4'd0, 64'h33, 1'b0);
        chk("bp3_held_ready", {63'd0, in_ready}, 64'd0);
        chk("bp3_held_data", out_data, 64'h11);
        cyc(1'b1, 64'h30, 64'h3, 4'd0, 64'h33, 1'b1);
        chk("bp_pop1_data", out_data, 64'h22);
        chk("bp_pop1_ready", {63'd0, in_ready}, 64'd1);
        cyc(1'b1, 64'h30, 64'h3, 4'd0, 64'h33, 1'b1);
        chk("bp_pop2_data", out_data, 64'h33);
        chk("bp_pop2_valid", {63'd0, out_valid}, 64'd1);
        cyc(1'b0, 64'h0, 64'h0, 4'd0, 64'h0, 1'b1);
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // Full throughput: 20 back-to-back commands, one result per cycle
        for (int i = 0; i < 20; i++) begin
            ai    = 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h1111);
            bi    = 64'(i % 5) + 64'd1;
            exp_d = alu(ai, bi, legal_cmds[i % 8]);
            cyc(1'b1, ai, bi, legal_cmds[i % 8], exp_d, 1'b1);
            chk("tp_valid", {63'd0, out_valid}, 64'd1);
            chk("tp_ready", {63'd0, in_ready}, 64'd1);
            chk("tp_data", out_data, exp_d);
        end
        cyc(1'b0, 64'h0, 64'h0, 4'd0, 64'h0, 1'b1);

        // Reset while full, with in_valid high
        cyc(1'b1, 64'h7, 64'h1, 4'd0, 64'h8, 1'b0);
        cyc(1'b1, 64'h9, 64'h1, 4'd0, 64'hA, 1'b0);
        chk("pre_rst_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        cyc(1'b1, 64'hB, 64'h1, 4'd0, 64'hC, 1'b0);
        rst = 1'b0;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_data", out_data, 64'd0);
        cyc(1'b0, 64'h0, 64'h0, 4'd0, 64'h0, 1'b1);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
